fetch_sequencer: RTL

Controls the fetch stage of the 5-stage RISC-V pipeline. It owns the PC and issues requests to an instruction memory port that uses a req/ack handshake and has variable latency. It applies redirects from execute (PCSrcE/PCTargetE) and honours decode stalls with a one-entry skid buffer. It produces the F/D pipeline register outputs InstrD, PCD, PCPlus4D and valid_d.

---
 rtl/fetch_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-stage controller for a 5-stage RISC-V pipeline. It owns the PC and
// issues one request at a time to an instruction memory port. That port uses a
// req/ack handshake with variable latency. Redirects from execute take priority
// over everything else. When decode stalls, a fetched word is parked in a
// one-entry skid buffer. The block drives the F/D pipeline register outputs.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous active-low reset
//   stall_d     decode cannot accept; F/D outputs hold
//   PCSrcE      redirect request from execute
//   PCTargetE   redirect target (bits [1:0] ignored)
//   imem_req    instruction memory request valid (registered)
//   imem_addr   word-aligned fetch address (registered)
//   imem_ack    response valid; imem_rdata valid in the same cycle
//   imem_rdata  fetched instruction
//   InstrD      instruction to decode
//   PCD         PC of InstrD
//   PCPlus4D    PCD + 4 (mod 2^32)
//   valid_d     InstrD is a real instruction
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | one cycle after reset, no request outstanding
// S_REQ   | request for pc is on the port, waiting for ack
// S_HOLD  | response parked in skid buffer while decode is stalled
// S_DRAIN | redirect taken while a request was in flight; wait for and
//         | discard its ack, pc already holds the new target
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_d,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] pc_plus4;
  logic [31:0] skid_pc_plus4;
  logic [31:0] target;
  logic        unused_target_lsbs;

  assign pc_plus4      = pc + 32'd4;
  assign skid_pc_plus4 = skid_pc + 32'd4;
  assign target        = {PCTargetE[31:2], 2'b00};

  // Low target bits are architecturally zero for this core.
  assign unused_target_lsbs = ^PCTargetE[1:0];

  // The PC register itself is the fetch address. It only changes on ack,
  // on a redirect, or on reset, so the address is stable while waiting.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      InstrD     <= NOP_INSTR;
      PCD        <= 32'h0000_0000;
      PCPlus4D   <= 32'h0000_0000;
      valid_d    <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (PCSrcE) begin
            pc         <= target;
            valid_d    <= 1'b0;
            InstrD     <= NOP_INSTR;
            skid_valid <= 1'b0;
          end
          state    <= S_REQ;
          imem_req <= 1'b1;
        end

        S_REQ: begin
          if (PCSrcE) begin
            pc         <= target;
            valid_d    <= 1'b0;
            InstrD     <= NOP_INSTR;
            skid_valid <= 1'b0;
            if (imem_ack) begin
              // Response arrived with the redirect: drop it, refetch at target.
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              // In-flight request cannot be cancelled; swallow its ack later.
              state    <= S_DRAIN;
              imem_req <= 1'b0;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (stall_d) begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_HOLD;
              imem_req   <= 1'b0;
            end else begin
              InstrD   <= imem_rdata;
              PCD      <= pc;
              PCPlus4D <= pc_plus4;
              valid_d  <= 1'b1;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end else if (!stall_d) begin
            // Bubble: PCD/PCPlus4D keep their last values.
            valid_d <= 1'b0;
            InstrD  <= NOP_INSTR;
          end
        end

        S_HOLD: begin
          if (PCSrcE) begin
            pc         <= target;
            valid_d    <= 1'b0;
            InstrD     <= NOP_INSTR;
            skid_valid <= 1'b0;
            state      <= S_REQ;
            imem_req   <= 1'b1;
          end else if (!stall_d) begin
            InstrD     <= skid_valid ? skid_instr : NOP_INSTR;
            PCD        <= skid_pc;
            PCPlus4D   <= skid_pc_plus4;
            valid_d    <= skid_valid;
            skid_valid <= 1'b0;
            state      <= S_REQ;
            imem_req   <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (PCSrcE) begin
            pc         <= target;
            valid_d    <= 1'b0;
            InstrD     <= NOP_INSTR;
            skid_valid <= 1'b0;
          end
          // A newer redirect only replaces the target. If the stale ack lands
          // in the same cycle, the port is free, so fetch at the newest target.
          if (imem_ack) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else begin
            state    <= S_DRAIN;
            imem_req <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Fetch addresses are always word aligned.
  a_addr_aligned : assert property (@(posedge clk) rst |-> (imem_addr[1:0] == 2'b00));

  // Once issued, a request and its address hold until the ack arrives.
  a_req_hold : assert property (@(posedge clk)
    (rst && imem_req && !imem_ack && !PCSrcE) |=> (imem_req && $stable(imem_addr)));

  // No new request may issue while a stale response is still owed.
  a_drain_quiet : assert property (@(posedge clk)
    (rst && state == S_DRAIN) |-> !imem_req);

endmodule
